// File: rtl/sha3_scan_pkg.sv
// Shared types for the SHA3 scan result path: scan lifecycle
// states, hash geometry and the result entry layout.
package sha3_scan_pkg;

  localparam int HASH_WORDS    = 25;
  localparam int HASH_KEEP_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCANNING = 2'd1,
    ST_DONE     = 2'd2
  } scan_state_t;

  // Nonce sits in the low word so 32-bit word j of an entry
  // is simply bits [32*j +: 32].
  typedef struct packed {
    logic [HASH_KEEP_DEF-1:0][63:0] hash;
    logic [31:0]                    nonce;
  } result_t;

  function automatic int entry_bits(input int keep);
    return 32 + 64 * keep;
  endfunction

endpackage

// File: rtl/sha3_result_fifo.sv
// Result FIFO: storage, wrapping pointers and occupancy count.
// Ports: clr/push/pop/wdata in; rdata (head), full, empty, count out.
module sha3_result_fifo
  import sha3_scan_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;
  logic          do_push;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop frees the slot a same-cycle push needs when full.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/sha3_scan_result_queue.sv
// Captures below-threshold scanner results into a FIFO, exposes
// the head word-by-word, tracks scan lifecycle and overflow losses.
module sha3_scan_result_queue
  import sha3_scan_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int HASH_KEEP = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                scan_start,
  input  logic                                found,
  input  logic [HASH_WORDS-1:0][63:0]         hash,
  input  logic [31:0]                         nonce,
  input  logic                                scanner_ready,
  input  logic                                pop,
  input  logic                                clear,
  input  logic [$clog2(1+2*HASH_KEEP)-1:0]    rd_sel,
  output logic [31:0]                         rd_data,
  output logic                                empty,
  output logic [$clog2(DEPTH):0]              count,
  output logic [15:0]                         dropped,
  output logic [31:0]                         found_total,
  output logic                                scanning,
  output logic                                done
);

  localparam int EW = entry_bits(HASH_KEEP);
  localparam int SW = $clog2(1+2*HASH_KEEP);
  localparam logic [SW-1:0] LAST = SW'(2*HASH_KEEP);

  scan_state_t   state;
  logic          armed;
  logic          prev_found;
  logic          cap;
  logic          full;
  logic          pop_ok;
  logic [EW-1:0] wentry;
  logic [EW-1:0] head;

  assign cap    = found & ~prev_found;
  assign pop_ok = pop & ~empty;
  assign wentry = {hash[HASH_KEEP-1:0], nonce};

  sha3_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (cap),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Clearing on start lets a found already high be seen once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   prev_found <= 1'b0;
    else if (clear | scan_start)  prev_found <= 1'b0;
    else                          prev_found <= found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped     <= '0;
      found_total <= '0;
    end else if (clear) begin
      dropped     <= '0;
      found_total <= '0;
    end else begin
      if (scan_start)  found_total <= '0;
      else if (cap)    found_total <= found_total + 1'b1;
      if (cap & full & ~pop_ok & (dropped != 16'hFFFF))
        dropped <= dropped + 1'b1;
    end
  end

  // armed masks the first SCANNING cycle, while the scanner's
  // ready is still reflecting the previous job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else if (scan_start) begin
      state <= ST_SCANNING;
      armed <= 1'b0;
    end else if (state == ST_SCANNING) begin
      if (!armed)             armed <= 1'b1;
      else if (scanner_ready) state <= ST_DONE;
    end
  end

  assign scanning = (state == ST_SCANNING);
  assign done     = (state == ST_DONE);

  always_comb begin
    rd_data = '0;
    if (!empty && rd_sel <= LAST)
      rd_data = head[32*int'(rd_sel) +: 32];
  end

endmodule
